// File: rtl/msi_bus_pkg.sv
// Shared definitions for the MSI snooping-bus controller:
// bus op codes, MSI line states, width defaults and FSM state codes.
package msi_bus_pkg;

  localparam logic [2:0] BUS_NONE  = 3'b000;
  localparam logic [2:0] BUS_RD    = 3'b001;
  localparam logic [2:0] BUS_UPGR  = 3'b010;
  localparam logic [2:0] BUS_FLUSH = 3'b011;
  localparam logic [2:0] BUS_RDX   = 3'b100;

  localparam logic [1:0] MSI_I = 2'b00;
  localparam logic [1:0] MSI_S = 2'b01;
  localparam logic [1:0] MSI_M = 2'b11;

  localparam int ADDR_W_DFLT = 5;
  localparam int DATA_W_DFLT = 16;

  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_OWNED = 5'b00010,
    ST_SNOOP = 5'b00100,
    ST_MEM   = 5'b01000,
    ST_RESP  = 5'b10000
  } ctrl_state_t;

  // Undefined encodings collapse to BusNone.
  function automatic logic [2:0] op_norm(input logic [2:0] op);
    return (op > BUS_RDX) ? BUS_NONE : op;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester after i_last, wrapping.
// Pure combinational, one-hot output, zero when nobody requests.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int LW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [LW-1:0] i_last,
  output logic [N-1:0]  o_pick
);

  logic w_found;
  int   w_idx;

  always_comb begin
    o_pick  = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 1; k <= N; k++) begin
      w_idx = (int'(i_last) + k) % N;
      if (!w_found && i_req[w_idx]) begin
        o_pick[w_idx] = 1'b1;
        w_found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/msi_bus_controller.sv
// Snooping-bus responder: arbitrates caches, broadcasts ops,
// resolves flush intervention and sequences memory access.
module msi_bus_controller
  import msi_bus_pkg::*;
#(
  parameter int N_CACHES     = 4,
  parameter int ADDR_W       = ADDR_W_DFLT,
  parameter int DATA_W       = DATA_W_DFLT,
  parameter int SNOOP_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_CACHES-1:0]        bus_request,
  output logic [N_CACHES-1:0]        bus_grant,
  input  logic [3*N_CACHES-1:0]      bus_op_out,
  input  logic [ADDR_W*N_CACHES-1:0] bus_addr_out,
  input  logic [DATA_W*N_CACHES-1:0] bus_dout,
  input  logic [N_CACHES-1:0]        bus_done_out,
  output logic [3*N_CACHES-1:0]      bus_op_in,
  output logic [ADDR_W*N_CACHES-1:0] bus_addr_in,
  output logic [DATA_W-1:0]          bus_din,
  output logic [N_CACHES-1:0]        bus_done_in,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic                       mem_read,
  output logic                       mem_write,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic [DATA_W-1:0]          mem_rdata,
  input  logic                       mem_done
);

  localparam int LW = (N_CACHES > 1) ? $clog2(N_CACHES) : 1;
  localparam int CW = $clog2(SNOOP_CYCLES + 1);

  ctrl_state_t r_state, w_state_nxt;
  logic [LW-1:0] r_master, w_master_nxt;
  logic [LW-1:0] r_last, w_last_nxt;
  logic [2:0] r_op, w_op_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [DATA_W-1:0] r_data, w_data_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic r_intv, w_intv_nxt;
  logic [N_CACHES-1:0] r_grant, w_grant_nxt;
  logic [N_CACHES-1:0] r_done_in, w_done_in_nxt;
  logic [3*N_CACHES-1:0] r_op_in, w_op_in_nxt;
  logic [ADDR_W*N_CACHES-1:0] r_addr_in, w_addr_in_nxt;
  logic [DATA_W-1:0] r_din, w_din_nxt;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
  logic r_mem_read, w_mem_read_nxt;
  logic r_mem_write, w_mem_write_nxt;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;

  logic [N_CACHES-1:0] w_pick;
  logic [LW-1:0] w_pick_idx;
  logic [2:0] w_op_m;
  logic [ADDR_W-1:0] w_addr_m;
  logic [DATA_W-1:0] w_dout_m;
  logic w_fl_hit;
  logic [DATA_W-1:0] w_fl_data;
  logic [3*N_CACHES-1:0] w_bc_op;
  logic [ADDR_W*N_CACHES-1:0] w_bc_addr;

  rr_arbiter #(.N(N_CACHES), .LW(LW)) u_arb (
    .i_req  (bus_request),
    .i_last (r_last),
    .o_pick (w_pick)
  );

  assign w_op_m   = op_norm(bus_op_out[3*int'(r_master) +: 3]);
  assign w_addr_m = bus_addr_out[ADDR_W*int'(r_master) +: ADDR_W];
  assign w_dout_m = bus_dout[DATA_W*int'(r_master) +: DATA_W];

  always_comb begin
    w_pick_idx = '0;
    w_fl_hit   = 1'b0;
    w_fl_data  = '0;
    w_bc_op    = '0;
    w_bc_addr  = r_addr_in;
    for (int k = 0; k < N_CACHES; k++) begin
      if (w_pick[k]) w_pick_idx = LW'(k);
      if (k != int'(r_master)) begin
        w_bc_op[3*k +: 3]           = r_op;
        w_bc_addr[ADDR_W*k +: ADDR_W] = r_addr;
      end
    end
    // Descending scan so the lowest-index flusher is the one kept.
    for (int k = N_CACHES - 1; k >= 0; k--) begin
      if (k != int'(r_master) &&
          op_norm(bus_op_out[3*k +: 3]) == BUS_FLUSH) begin
        w_fl_hit  = 1'b1;
        w_fl_data = bus_dout[DATA_W*k +: DATA_W];
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_master_nxt    = r_master;
    w_last_nxt      = r_last;
    w_op_nxt        = r_op;
    w_addr_nxt      = r_addr;
    w_data_nxt      = r_data;
    w_cnt_nxt       = r_cnt;
    w_intv_nxt      = r_intv;
    w_grant_nxt     = r_grant;
    w_done_in_nxt   = '0;
    w_op_in_nxt     = r_op_in;
    w_addr_in_nxt   = r_addr_in;
    w_din_nxt       = r_din;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_read_nxt  = r_mem_read;
    w_mem_write_nxt = r_mem_write;
    w_mem_wdata_nxt = r_mem_wdata;
    unique case (r_state)
      ST_IDLE: begin
        if (|bus_request) begin
          w_master_nxt = w_pick_idx;
          w_grant_nxt  = w_pick;
          w_state_nxt  = ST_OWNED;
        end
      end
      ST_OWNED: begin
        if (bus_done_out[r_master]) begin
          w_grant_nxt = '0;
          w_last_nxt  = r_master;
          w_state_nxt = ST_IDLE;
        end else if (w_op_m != BUS_NONE) begin
          w_op_nxt   = w_op_m;
          w_addr_nxt = w_addr_m;
          if (w_op_m == BUS_FLUSH) begin
            w_data_nxt      = w_dout_m;
            w_mem_addr_nxt  = w_addr_m;
            w_mem_wdata_nxt = w_dout_m;
            w_mem_write_nxt = 1'b1;
            w_state_nxt     = ST_MEM;
          end else begin
            w_cnt_nxt   = '0;
            w_intv_nxt  = 1'b0;
            w_state_nxt = ST_SNOOP;
          end
        end
      end
      ST_SNOOP: begin
        w_cnt_nxt = r_cnt + CW'(1);
        // Responses only count once the broadcast is on the wires.
        if (r_cnt != '0 && !r_intv && w_fl_hit) begin
          w_intv_nxt = 1'b1;
          w_data_nxt = w_fl_data;
        end
        if (r_cnt == CW'(SNOOP_CYCLES)) begin
          w_op_in_nxt = '0;
          if (r_op == BUS_UPGR) begin
            w_done_in_nxt = r_grant;
            w_state_nxt   = ST_RESP;
          end else if (w_intv_nxt) begin
            w_mem_addr_nxt  = r_addr;
            w_mem_wdata_nxt = w_data_nxt;
            w_mem_write_nxt = 1'b1;
            w_state_nxt     = ST_MEM;
          end else begin
            w_mem_addr_nxt = r_addr;
            w_mem_read_nxt = 1'b1;
            w_state_nxt    = ST_MEM;
          end
        end else begin
          w_op_in_nxt   = w_bc_op;
          w_addr_in_nxt = w_bc_addr;
        end
      end
      ST_MEM: begin
        if (mem_done) begin
          w_mem_read_nxt  = 1'b0;
          w_mem_write_nxt = 1'b0;
          w_data_nxt      = r_mem_read ? mem_rdata : r_data;
          w_din_nxt       = w_data_nxt;
          w_done_in_nxt   = r_grant;
          w_state_nxt     = ST_RESP;
        end
      end
      ST_RESP: w_state_nxt = ST_OWNED;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_master    <= '0;
      r_last      <= LW'(N_CACHES - 1);
      r_op        <= BUS_NONE;
      r_addr      <= '0;
      r_data      <= '0;
      r_cnt       <= '0;
      r_intv      <= 1'b0;
      r_grant     <= '0;
      r_done_in   <= '0;
      r_op_in     <= '0;
      r_addr_in   <= '0;
      r_din       <= '0;
      r_mem_addr  <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_master    <= w_master_nxt;
      r_last      <= w_last_nxt;
      r_op        <= w_op_nxt;
      r_addr      <= w_addr_nxt;
      r_data      <= w_data_nxt;
      r_cnt       <= w_cnt_nxt;
      r_intv      <= w_intv_nxt;
      r_grant     <= w_grant_nxt;
      r_done_in   <= w_done_in_nxt;
      r_op_in     <= w_op_in_nxt;
      r_addr_in   <= w_addr_in_nxt;
      r_din       <= w_din_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_read  <= w_mem_read_nxt;
      r_mem_write <= w_mem_write_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
    end
  end

  assign bus_grant   = r_grant;
  assign bus_done_in = r_done_in;
  assign bus_op_in   = r_op_in;
  assign bus_addr_in = r_addr_in;
  assign bus_din     = r_din;
  assign mem_addr    = r_mem_addr;
  assign mem_read    = r_mem_read;
  assign mem_write   = r_mem_write;
  assign mem_wdata   = r_mem_wdata;

endmodule

// File: tb/tb_msi_bus_controller.sv
// Directed bench for msi_bus_controller with a small
// latency-modelled memory and immediate-assertion checks.
module tb_msi_bus_controller;
  import msi_bus_pkg::*;

  localparam int N  = 4;
  localparam int AW = 5;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] bus_request, bus_grant, bus_done_out, bus_done_in;
  logic [3*N-1:0] bus_op_out, bus_op_in;
  logic [AW*N-1:0] bus_addr_out, bus_addr_in;
  logic [DW*N-1:0] bus_dout;
  logic [DW-1:0] bus_din, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic mem_read, mem_write, mem_done;

  logic [DW-1:0] mem [32];
  int wait_cnt = 0;
  int rd_cycles = 0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  msi_bus_controller #(
    .N_CACHES(N), .ADDR_W(AW), .DATA_W(DW), .SNOOP_CYCLES(2)
  ) dut (
    .clk(clk), .reset(reset),
    .bus_request(bus_request), .bus_grant(bus_grant),
    .bus_op_out(bus_op_out), .bus_addr_out(bus_addr_out),
    .bus_dout(bus_dout), .bus_done_out(bus_done_out),
    .bus_op_in(bus_op_in), .bus_addr_in(bus_addr_in),
    .bus_din(bus_din), .bus_done_in(bus_done_in),
    .mem_addr(mem_addr), .mem_read(mem_read),
    .mem_write(mem_write), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done)
  );

  // Memory answers two cycles after it first sees a strobe.
  always @(posedge clk) begin
    mem_done <= 1'b0;
    if (reset) begin
      wait_cnt  <= 0;
      mem_rdata <= '0;
      for (int i = 0; i < 32; i++)
        mem[i] <= (i == 0) ? 16'h0001 : (i == 4) ? 16'h0004 : 16'h0000;
    end else begin
      if (mem_read) rd_cycles <= rd_cycles + 1;
      if ((mem_read || mem_write) && !mem_done) begin
        if (wait_cnt == 2) begin
          wait_cnt  <= 0;
          mem_done  <= 1'b1;
          mem_rdata <= mem[mem_addr];
          if (mem_write) mem[mem_addr] <= mem_wdata;
        end else begin
          wait_cnt <= wait_cnt + 1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_op(input int k, input logic [2:0] op,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus_op_out[3*k +: 3]    = op;
    bus_addr_out[AW*k +: AW] = a;
    bus_dout[DW*k +: DW]     = d;
  endtask

  task automatic wait_mem(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (mem_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic release_bus(input int k, input string tag);
    bus_done_out[k] = 1'b1;
    step();
    chk(tag, 32'(bus_grant), 32'd0);
    bus_done_out[k] = 1'b0;
  endtask

  int rd_snap;
  int seq [5] = '{0, 1, 2, 3, 0};

  initial begin
    bus_request  = '0;
    bus_op_out   = '0;
    bus_addr_out = '0;
    bus_dout     = '0;
    bus_done_out = '0;
    step();
    step();
    chk("rst_grant", 32'(bus_grant), 32'd0);
    chk("rst_done_in", 32'(bus_done_in), 32'd0);
    chk("rst_op_in", 32'(bus_op_in), 32'd0);
    chk("rst_addr_in", 32'(bus_addr_in), 32'd0);
    chk("rst_din", 32'(bus_din), 32'd0);
    chk("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    reset = 1'b0;

    // Cache 0 BusRd @0
    bus_request[0] = 1'b1;
    step();
    chk("rd_grant", 32'(bus_grant), 32'h1);
    drive_op(0, BUS_RD, 5'd0, 16'h0);
    step();
    drive_op(0, BUS_NONE, 5'd0, 16'h0);
    chk("rd_bc_delay", 32'(bus_op_in), 32'h000);
    step();
    chk("rd_bc1", 32'(bus_op_in), 32'h248);
    step();
    chk("rd_bc2", 32'(bus_op_in), 32'h248);
    step();
    chk("rd_bc_end", 32'(bus_op_in), 32'h000);
    chk("rd_strobe", 32'(mem_read), 32'd1);
    wait_mem("rd_memdone");
    chk("rd_held", 32'(mem_read), 32'd1);
    step();
    chk("rd_done_in", 32'(bus_done_in), 32'h1);
    chk("rd_din", 32'(bus_din), 32'h0001);
    chk("rd_strobe_off", 32'(mem_read), 32'd0);
    step();
    chk("rd_pulse", 32'(bus_done_in), 32'h0);
    bus_request[0] = 1'b0;
    release_bus(0, "rd_release");

    // Cache 1 BusUpgr @4
    rd_snap = rd_cycles;
    bus_request[1] = 1'b1;
    step();
    chk("up_grant", 32'(bus_grant), 32'h2);
    drive_op(1, BUS_UPGR, 5'd4, 16'h0);
    step();
    drive_op(1, BUS_NONE, 5'd0, 16'h0);
    step();
    chk("up_bc", 32'(bus_op_in), 32'h482);
    chk("up_addr_c0", 32'(bus_addr_in[4:0]), 32'd4);
    chk("up_addr_c3", 32'(bus_addr_in[19:15]), 32'd4);
    step();
    chk("up_early", 32'(bus_done_in), 32'h0);
    step();
    chk("up_done_in", 32'(bus_done_in), 32'h2);
    chk("up_no_mem", {30'd0, mem_read, mem_write}, 32'd0);
    step();
    chk("up_pulse", 32'(bus_done_in), 32'h0);
    chk("up_rd_cnt", rd_cycles, rd_snap);
    bus_request[1] = 1'b0;
    release_bus(1, "up_release");

    // Cache 2 BusRdX @4, cache 3 intervenes with 00AB
    rd_snap = rd_cycles;
    bus_request[2] = 1'b1;
    step();
    chk("rdx_grant", 32'(bus_grant), 32'h4);
    drive_op(2, BUS_RDX, 5'd4, 16'h0);
    step();
    drive_op(2, BUS_NONE, 5'd0, 16'h0);
    drive_op(3, BUS_FLUSH, 5'd4, 16'h00AB);
    step();
    chk("rdx_bc3", 32'(bus_op_in[11:9]), 32'(BUS_RDX));
    step();
    drive_op(3, BUS_NONE, 5'd0, 16'h0);
    step();
    chk("rdx_wr", {30'd0, mem_read, mem_write}, 32'd1);
    chk("rdx_wr_addr", 32'(mem_addr), 32'd4);
    chk("rdx_wr_data", 32'(mem_wdata), 32'h00AB);
    wait_mem("rdx_memdone");
    step();
    chk("rdx_done_in", 32'(bus_done_in), 32'h4);
    chk("rdx_din", 32'(bus_din), 32'h00AB);
    chk("rdx_mem4", 32'(mem[4]), 32'h00AB);
    chk("rdx_no_read", rd_cycles, rd_snap);
    step();
    bus_request[2] = 1'b0;
    release_bus(2, "rdx_release");

    // Cache 0: Flush @4 then BusRdX @0 under one grant
    bus_request[0] = 1'b1;
    step();
    chk("fl_grant", 32'(bus_grant), 32'h1);
    drive_op(0, BUS_FLUSH, 5'd4, 16'h000D);
    step();
    drive_op(0, BUS_NONE, 5'd0, 16'h0);
    chk("fl_wr", 32'(mem_write), 32'd1);
    chk("fl_wdata", 32'(mem_wdata), 32'h000D);
    wait_mem("fl_memdone");
    step();
    chk("fl_done_in", 32'(bus_done_in), 32'h1);
    chk("fl_mem4", 32'(mem[4]), 32'h000D);
    step();
    drive_op(0, BUS_RDX, 5'd0, 16'h0);
    step();
    drive_op(0, BUS_NONE, 5'd0, 16'h0);
    step();
    step();
    step();
    chk("fl_rdx_rd", 32'(mem_read), 32'd1);
    wait_mem("fl_rdx_memdone");
    step();
    chk("fl_rdx_done", 32'(bus_done_in), 32'h1);
    chk("fl_rdx_din", 32'(bus_din), 32'h0001);
    chk("fl_grant_kept", 32'(bus_grant), 32'h1);
    step();
    bus_request[0] = 1'b0;
    release_bus(0, "fl_release");

    // Reset in the middle of a memory read
    bus_request[0] = 1'b1;
    step();
    chk("ab_grant", 32'(bus_grant), 32'h1);
    drive_op(0, BUS_RD, 5'd0, 16'h0);
    step();
    drive_op(0, BUS_NONE, 5'd0, 16'h0);
    step();
    step();
    step();
    chk("ab_in_mem", 32'(mem_read), 32'd1);
    reset = 1'b1;
    bus_request = '0;
    step();
    chk("ab_grant0", 32'(bus_grant), 32'd0);
    chk("ab_rd0", 32'(mem_read), 32'd0);
    chk("ab_op_in0", 32'(bus_op_in), 32'd0);
    reset = 1'b0;

    // All caches request continuously
    bus_request = '1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rr_grant", 32'(bus_grant), 32'(1) << seq[i]);
      release_bus(seq[i], "rr_idle_gap");
    end
    bus_request = '0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
